gate_exerciser: RTL and testbench

- Self-test initiator for the 3-gate logic block: AND on inputs 0/1, XOR on inputs 4/5, OR on inputs 2/3.
- Drives all 64 six-bit input vectors onto the gate block's inputs and waits a programmable settle time per vector.
- Samples the gate block's 3 outputs, compares them against a golden model, and reports pass/fail, error count and first failing vector.
- Sits on-chip beside the gate block; a host pulses start and reads the results.

---
 rtl/gate_exerciser_pkg.sv | 17 +
 rtl/gate_ref_model.sv | 13 +
 rtl/gate_exerciser.sv | 154 +++++++++++++++
 tb/tb_gate_exerciser.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_exerciser_pkg.sv
// Shared types and widths for the gate-block self-test initiator.
package gate_exerciser_pkg;

  localparam int VEC_W   = 6;
  localparam int OBS_W   = 3;
  localparam int NUM_VEC = 64;
  localparam int CNT_W   = 4;
  localparam int ERR_W   = 7;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden model of the 3-gate block: AND on v[1:0], XOR on v[5:4], OR on v[3:2].
module gate_ref_model
  import gate_exerciser_pkg::*;
(
  input  logic [VEC_W-1:0] v,
  output logic [OBS_W-1:0] exp
);

  assign exp[0] = v[0] & v[1];
  assign exp[1] = v[4] ^ v[5];
  assign exp[2] = v[2] | v[3];

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps all 64 stimulus vectors into the gate block, waits SETTLE_CYCLES per
// vector, and scores the sampled outputs against the golden model.
//
// state   | meaning
// IDLE    | results held, waiting for start
// SETTLE  | vector applied, settle down-counter running
// COMPARE | sense sampled and scored against the golden model
// DONE    | sweep finished; done pulse and pass issued on exit
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] drive,
  input  logic [OBS_W-1:0] sense,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic [OBS_W-1:0] first_fail_obs
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [OBS_W-1:0] exp_obs;
  logic             mismatch;
  logic             last_vec;
  logic             cnt_zero;

  gate_ref_model u_ref (
    .v   (drive),
    .exp (exp_obs)
  );

  assign mismatch = (sense != exp_obs);
  assign last_vec = (drive == VEC_W'(NUM_VEC - 1));
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_vec) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Abort drops the sweep but leaves the partial error record readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive          <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
      first_fail_obs <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            drive          <= '0;
            cnt            <= CNT_LOAD;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_obs <= '0;
          end
        end
        SETTLE: begin
          if (abort) begin
            drive <= '0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        COMPARE: begin
          if (abort) begin
            drive <= '0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_count + ERR_W'(1);
              if (err_count == '0) begin
                first_fail_vec <= drive;
                first_fail_obs <= sense;
              end
            end
            if (!last_vec) begin
              drive <= drive + VEC_W'(1);
              cnt   <= CNT_LOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
          drive <= '0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two instances (settle 2 and settle 1) driven by
// behavioural gate-block models, scored every cycle against a timeline model.
module tb_gate_exerciser;
  import gate_exerciser_pkg::*;

  localparam int NI = 2;

  logic       clk;
  logic       rst;
  logic       start     [NI];
  logic       abort     [NI];
  logic [5:0] drive     [NI];
  logic [2:0] sense     [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       pass      [NI];
  logic [6:0] err_count [NI];
  logic [5:0] ffv       [NI];
  logic [2:0] ffo       [NI];

  int mode [NI];
  logic [5:0] drv_d1 [NI];
  logic [5:0] drv_d2 [NI];
  logic [2:0] noise  [NI];

  int n_checks = 0;
  int n_errors = 0;

  int  m_k    [NI];
  int  m_err  [NI];
  int  m_ffv  [NI];
  int  m_ffo  [NI];
  bit  m_act  [NI];
  bit  m_done [NI];
  bit  m_pass [NI];

  function automatic int s_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Gate-block truth computed from bit-pair arithmetic.
  function automatic logic [2:0] golden(int v);
    logic [2:0] r;
    r[0] = ((v & 3) == 3);
    r[1] = (((v >> 4) & 3) == 1) || (((v >> 4) & 3) == 2);
    r[2] = (((v >> 2) & 3) != 0);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modes: 0 ideal, 1 sense[1] stuck 0, 2 sense[2] inverted,
  // 3 one-cycle delay, 4 two-cycle delay, 5 random bit corruption.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    gate_exerciser #(.SETTLE_CYCLES(g == 0 ? 2 : 1)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start[g]),
      .abort          (abort[g]),
      .drive          (drive[g]),
      .sense          (sense[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .err_count      (err_count[g]),
      .first_fail_vec (ffv[g]),
      .first_fail_obs (ffo[g])
    );

    always @(posedge clk) begin
      drv_d1[g] <= drive[g];
      drv_d2[g] <= drv_d1[g];
      noise[g]  <= ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
    end

    always_comb begin
      case (mode[g])
        1:       sense[g] = golden(int'(drive[g])) & 3'b101;
        2:       sense[g] = golden(int'(drive[g])) ^ 3'b100;
        3:       sense[g] = golden(int'(drv_d1[g]));
        4:       sense[g] = golden(int'(drv_d2[g]));
        5:       sense[g] = golden(int'(drive[g])) ^ noise[g];
        default: sense[g] = golden(int'(drive[g]));
      endcase
    end
  end

  // Timeline model: k counts cycles since the accepted start edge; vector
  // k/(S+1) is applied, the last cycle of each slot is its compare cycle.
  always @(negedge clk) begin
    int p, last, exp_drv, v;
    for (int i = 0; i < NI; i++) begin
      p    = s_of(i) + 1;
      last = NUM_VEC * p;
      if (rst) begin
        m_act[i]  = 1'b0;
        m_k[i]    = 0;
        m_done[i] = 1'b0;
        m_pass[i] = 1'b0;
        m_err[i]  = 0;
        m_ffv[i]  = 0;
        m_ffo[i]  = 0;
      end
      exp_drv = !m_act[i] ? 0 : ((m_k[i] < last) ? m_k[i] / p : NUM_VEC - 1);
      check($sformatf("u%0d_busy", i), 32'(busy[i]), 32'(m_act[i]));
      check($sformatf("u%0d_done", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("u%0d_pass", i), 32'(pass[i]), 32'(m_pass[i]));
      check($sformatf("u%0d_drive", i), 32'(drive[i]), exp_drv);
      check($sformatf("u%0d_err_count", i), 32'(err_count[i]), m_err[i]);
      check($sformatf("u%0d_first_fail_vec", i), 32'(ffv[i]), m_ffv[i]);
      check($sformatf("u%0d_first_fail_obs", i), 32'(ffo[i]), m_ffo[i]);
      if (!rst) begin
        m_done[i] = 1'b0;
        if (!m_act[i]) begin
          if (start[i] && !abort[i]) begin
            m_act[i]  = 1'b1;
            m_k[i]    = 0;
            m_pass[i] = 1'b0;
            m_err[i]  = 0;
            m_ffv[i]  = 0;
            m_ffo[i]  = 0;
          end
        end else if (abort[i] && m_k[i] < last) begin
          m_act[i]  = 1'b0;
          m_pass[i] = 1'b0;
        end else begin
          if (m_k[i] < last && (m_k[i] % p) == p - 1) begin
            v = m_k[i] / p;
            if (sense[i] !== golden(v)) begin
              if (m_err[i] == 0) begin
                m_ffv[i] = v;
                m_ffo[i] = int'(sense[i]);
              end
              m_err[i]++;
            end
          end
          if (m_k[i] == last) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
            m_pass[i] = (m_err[i] == 0);
          end else begin
            m_k[i]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic run_to_done(int i, int budget, output int n);
    n = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (done[i] !== 1'b1) check($sformatf("u%0d_done_timeout", i), 32'(done[i]), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_tot, cnt_done;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      mode[i]  = 0;
    end
    repeat (3) tick();
    check("reset_busy", 32'(busy[0]), 0);
    check("reset_drive", 32'(drive[0]), 0);
    check("reset_err_count", 32'(err_count[0]), 0);
    check("reset_pass", 32'(pass[0]), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Ideal sweep with an ignored start while busy.
    pulse_start(0);
    repeat (50) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n_tot = 51;
    run_to_done(0, 400, n);
    check("ideal_done_latency", n_tot + n, 193);
    check("ideal_pass", 32'(pass[0]), 1);
    check("ideal_err_count", 32'(err_count[0]), 0);
    check("ideal_drive_end", 32'(drive[0]), 0);
    repeat (3) tick();

    mode[0] = 1;
    pulse_start(0);
    run_to_done(0, 400, n);
    check("stuck1_err_count", 32'(err_count[0]), 32);
    check("stuck1_first_vec", 32'(ffv[0]), 32'b010000);
    check("stuck1_first_obs", 32'(ffo[0]), 0);
    check("stuck1_pass", 32'(pass[0]), 0);
    repeat (3) tick();

    mode[0] = 2;
    pulse_start(0);
    run_to_done(0, 400, n);
    check("inv2_err_count", 32'(err_count[0]), 64);
    check("inv2_first_vec", 32'(ffv[0]), 0);
    check("inv2_first_obs", 32'(ffo[0]), 32'b100);
    repeat (3) tick();

    mode[1] = 3;
    pulse_start(1);
    run_to_done(1, 400, n);
    check("s1_delay1_latency", n, 129);
    check("s1_delay1_err_count", 32'(err_count[1]), 0);
    check("s1_delay1_pass", 32'(pass[1]), 1);
    repeat (3) tick();
    mode[1] = 4;
    pulse_start(1);
    run_to_done(1, 400, n);
    check("s1_delay2_err_nonzero", 32'(err_count[1] != 0), 1);
    check("s1_delay2_pass", 32'(pass[1]), 0);
    repeat (3) tick();

    // Abort plus start during vector 20 of a failing sweep.
    mode[0] = 2;
    pulse_start(0);
    n = 0;
    while (drive[0] !== 6'd20 && n < 500) begin
      tick();
      n++;
    end
    check("abort_reach_vec20", 32'(drive[0]), 20);
    abort[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    start[0] = 1'b0;
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_drive", 32'(drive[0]), 0);
    check("abort_pass", 32'(pass[0]), 0);
    check("abort_partial_err", 32'(err_count[0]), 20);
    cnt_done = 0;
    repeat (250) begin
      tick();
      if (done[0] === 1'b1) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);
    mode[0] = 0;
    pulse_start(0);
    check("restart_drive", 32'(drive[0]), 0);
    check("restart_err_cleared", 32'(err_count[0]), 0);
    check("restart_busy", 32'(busy[0]), 1);
    run_to_done(0, 400, n);
    check("restart_pass", 32'(pass[0]), 1);
    repeat (3) tick();

    // Asynchronous reset between clock edges mid-sweep.
    pulse_start(0);
    repeat (30) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy[0]), 0);
    check("midrst_drive", 32'(drive[0]), 0);
    check("midrst_err_count", 32'(err_count[0]), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Randomized sweeps with random fault modes, aborts and stray starts.
    for (int it = 0; it < 8; it++) begin
      int i;
      i = int'($urandom_range(0, 1));
      mode[i] = int'($urandom_range(0, 5));
      pulse_start(i);
      n = 0;
      while (busy[i] === 1'b1 && n < 400) begin
        abort[i] = ($urandom_range(0, 119) == 0);
        start[i] = ($urandom_range(0, 39) == 0);
        tick();
        n++;
      end
      abort[i] = 1'b0;
      start[i] = 1'b0;
      check($sformatf("rand%0d_finished", it), 32'(busy[i]), 0);
      repeat (4) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
